// File: rtl/joystick_pkg.sv
// Shared types and default thresholds for the joystick stepper.
package joystick_pkg;

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        CENTER  = 2'd1,
        UP_HELD = 2'd2,
        DN_HELD = 2'd3
    } axis_state_e;

    typedef enum logic [1:0] {
        Z_DN  = 2'd0,
        Z_MID = 2'd1,
        Z_UP  = 2'd2
    } zone_e;

    localparam int DEF_HI_TH = 'h800;
    localparam int DEF_LO_TH = 'h300;
    localparam int DEF_HYST  = 'h040;

endpackage

// File: rtl/joystick_stepper_if.sv
// Sample-in / value-out bundle between the ADC front end and the stepper.
interface joystick_stepper_if #(
    parameter int NCH   = 2,
    parameter int ADC_W = 12,
    parameter int VAL_W = 4
);
    logic                   adc_valid;
    logic [NCH*ADC_W-1:0]   adc_data;
    logic [NCH*VAL_W-1:0]   val;
    logic [NCH-1:0]         step_up;
    logic [NCH-1:0]         step_dn;

    modport master (output adc_valid, adc_data, input val, step_up, step_dn);
    modport slave  (input adc_valid, adc_data, output val, step_up, step_dn);
endinterface

// File: rtl/joystick_axis.sv
// One joystick axis: zone classification, hold FSM, value counter and,
// when JOYSTICK_STEPPER_AUTO_REPEAT_EN is defined, a held-sample repeat counter.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ARM     | after reset; waits for a centred sample, never steps
//   CENTER  | stick centred; a deflection steps once and enters a hold
//   UP_HELD | stepped up; waits for centre (with hysteresis) or reversal
//   DN_HELD | stepped down; mirror of UP_HELD
module joystick_axis
    import joystick_pkg::*;
#(
    parameter int ADC_W   = 12,
    parameter int VAL_W   = 4,
    parameter int VAL_MAX = 15,
    parameter int HI_TH   = DEF_HI_TH,
    parameter int LO_TH   = DEF_LO_TH,
    parameter int HYST    = DEF_HYST,
    parameter int SAT     = 0,
    parameter int RPT_DLY = 8,
    parameter int RPT_PER = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] sample,
    output logic [VAL_W-1:0] val,
    output logic             step_up,
    output logic             step_dn
);

    // Reject parameter sets the counters cannot honour.
    if (VAL_MAX > (2**VAL_W - 1) || RPT_DLY < 2 || RPT_PER < 1) begin : g_bad_params
        $error("joystick_axis: illegal VAL_MAX/RPT_DLY/RPT_PER");
    end

    localparam logic [ADC_W-1:0] HI_T  = ADC_W'(HI_TH);
    localparam logic [ADC_W-1:0] LO_T  = ADC_W'(LO_TH);
    localparam logic [ADC_W-1:0] CEN_L = ADC_W'(LO_TH + HYST);
    localparam logic [ADC_W-1:0] CEN_H = ADC_W'(HI_TH - HYST);
    localparam logic [VAL_W-1:0] MAXV  = VAL_W'(VAL_MAX);

    axis_state_e      state;
    zone_e            zone;
    logic             centre;
    logic             at_max;
    logic             at_min;
    logic             can_inc;
    logic             can_dec;
    logic [VAL_W-1:0] inc_val;
    logic [VAL_W-1:0] dec_val;

`ifdef JOYSTICK_STEPPER_AUTO_REPEAT_EN
    localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    // Loaded on entry to a hold: the entry sample already counts as held sample 1.
    localparam logic [RPT_W-1:0] RPT_FIRST  = RPT_W'(RPT_DLY - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(RPT_PER);
    logic [RPT_W-1:0] rpt_cnt;
`endif

    // Classify the sample and precompute the wrapped/clamped neighbours of val.
    always_comb begin
        zone = Z_MID;
        if (sample > HI_T)
            zone = Z_UP;
        else if (sample <= LO_T)
            zone = Z_DN;
        centre  = (sample > CEN_L) && (sample <= CEN_H);
        at_max  = (val == MAXV);
        at_min  = (val == '0);
        can_inc = !((SAT != 0) && at_max);
        can_dec = !((SAT != 0) && at_min);
        inc_val = at_max ? ((SAT != 0) ? val : '0) : val + 1'b1;
        dec_val = at_min ? ((SAT != 0) ? val : MAXV) : val - 1'b1;
    end

    // Axis FSM with registered value and one-cycle step pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ARM;
            val     <= '0;
            step_up <= 1'b0;
            step_dn <= 1'b0;
`ifdef JOYSTICK_STEPPER_AUTO_REPEAT_EN
            rpt_cnt <= '0;
`endif
        end else begin
            step_up <= 1'b0;
            step_dn <= 1'b0;
            if (adc_valid) begin
                case (state)
                    ARM: begin
                        if (centre)
                            state <= CENTER;
                    end
                    CENTER: begin
                        if (zone == Z_UP) begin
                            state   <= UP_HELD;
                            val     <= inc_val;
                            step_up <= can_inc;
`ifdef JOYSTICK_STEPPER_AUTO_REPEAT_EN
                            rpt_cnt <= RPT_FIRST;
`endif
                        end else if (zone == Z_DN) begin
                            state   <= DN_HELD;
                            val     <= dec_val;
                            step_dn <= can_dec;
`ifdef JOYSTICK_STEPPER_AUTO_REPEAT_EN
                            rpt_cnt <= RPT_FIRST;
`endif
                        end
                    end
                    UP_HELD: begin
                        if (centre) begin
                            state <= CENTER;
`ifdef JOYSTICK_STEPPER_AUTO_REPEAT_EN
                            rpt_cnt <= '0;
`endif
                        end else if (zone == Z_DN) begin
                            state   <= DN_HELD;
                            val     <= dec_val;
                            step_dn <= can_dec;
`ifdef JOYSTICK_STEPPER_AUTO_REPEAT_EN
                            rpt_cnt <= RPT_FIRST;
                        end else if (zone == Z_UP) begin
                            if (rpt_cnt == RPT_W'(1)) begin
                                val     <= inc_val;
                                step_up <= can_inc;
                                rpt_cnt <= RPT_RELOAD;
                            end else begin
                                rpt_cnt <= rpt_cnt - 1'b1;
                            end
`endif
                        end
                    end
                    DN_HELD: begin
                        if (centre) begin
                            state <= CENTER;
`ifdef JOYSTICK_STEPPER_AUTO_REPEAT_EN
                            rpt_cnt <= '0;
`endif
                        end else if (zone == Z_UP) begin
                            state   <= UP_HELD;
                            val     <= inc_val;
                            step_up <= can_inc;
`ifdef JOYSTICK_STEPPER_AUTO_REPEAT_EN
                            rpt_cnt <= RPT_FIRST;
                        end else if (zone == Z_DN) begin
                            if (rpt_cnt == RPT_W'(1)) begin
                                val     <= dec_val;
                                step_dn <= can_dec;
                                rpt_cnt <= RPT_RELOAD;
                            end else begin
                                rpt_cnt <= rpt_cnt - 1'b1;
                            end
`endif
                        end
                    end
                    default: state <= ARM;
                endcase
            end
        end
    end

endmodule

// File: rtl/joystick_stepper.sv
// Multi-channel joystick stepper: NCH independent axes, each stepping a
// VAL_W-bit value from its own ADC channel. Optional auto-repeat is enabled
// by defining JOYSTICK_STEPPER_AUTO_REPEAT_EN.
module joystick_stepper
    import joystick_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int ADC_W   = 12,
    parameter int VAL_W   = 4,
    parameter int VAL_MAX = 15,
    parameter int HI_TH   = DEF_HI_TH,
    parameter int LO_TH   = DEF_LO_TH,
    parameter int HYST    = DEF_HYST,
    parameter int SAT     = 0,
    parameter int RPT_DLY = 8,
    parameter int RPT_PER = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    joystick_stepper_if.slave  bus
);

    // One axis instance per channel; channels share only clock, reset and strobe.
    for (genvar i = 0; i < NCH; i++) begin : g_axis
        joystick_axis #(
            .ADC_W   (ADC_W),
            .VAL_W   (VAL_W),
            .VAL_MAX (VAL_MAX),
            .HI_TH   (HI_TH),
            .LO_TH   (LO_TH),
            .HYST    (HYST),
            .SAT     (SAT),
            .RPT_DLY (RPT_DLY),
            .RPT_PER (RPT_PER)
        ) u_axis (
            .clk       (clk),
            .reset_n   (reset_n),
            .adc_valid (bus.adc_valid),
            .sample    (bus.adc_data[i*ADC_W +: ADC_W]),
            .val       (bus.val[i*VAL_W +: VAL_W]),
            .step_up   (bus.step_up[i]),
            .step_dn   (bus.step_dn[i])
        );
    end

endmodule

// File: tb/tb_joystick_stepper.sv
// Directed bench: a wrapping (SAT=0) and a clamping (SAT=1) instance share
// identical stimulus; expected values are hand-tracked per step.
module tb_joystick_stepper;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        adc_valid = 1'b0;
    logic [23:0] adc_data = '0;

    int checks = 0;
    int failures = 0;

    joystick_stepper_if #(.NCH(2), .ADC_W(12), .VAL_W(4)) if_w ();
    joystick_stepper_if #(.NCH(2), .ADC_W(12), .VAL_W(4)) if_s ();

    assign if_w.adc_valid = adc_valid;
    assign if_w.adc_data  = adc_data;
    assign if_s.adc_valid = adc_valid;
    assign if_s.adc_data  = adc_data;

    joystick_stepper #(.SAT(0)) dut_w (.clk(clk), .reset_n(reset_n), .bus(if_w.slave));
    joystick_stepper #(.SAT(1)) dut_s (.clk(clk), .reset_n(reset_n), .bus(if_s.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compare both instances: values per channel and step vectors.
    task automatic chk_all(input string tag,
                           input int w0, input int w1, input int wu, input int wd,
                           input int s0, input int s1, input int su, input int sd);
        check({tag, " w.val0"}, int'(if_w.val[3:0]), w0);
        check({tag, " w.val1"}, int'(if_w.val[7:4]), w1);
        check({tag, " w.up"},   int'(if_w.step_up),  wu);
        check({tag, " w.dn"},   int'(if_w.step_dn),  wd);
        check({tag, " s.val0"}, int'(if_s.val[3:0]), s0);
        check({tag, " s.val1"}, int'(if_s.val[7:4]), s1);
        check({tag, " s.up"},   int'(if_s.step_up),  su);
        check({tag, " s.dn"},   int'(if_s.step_dn),  sd);
    endtask

    // One valid sample; returns at the following negedge with outputs settled.
    task automatic send(input logic [11:0] ch0, input logic [11:0] ch1);
        @(negedge clk);
        adc_valid = 1'b1;
        adc_data  = {ch1, ch0};
        @(negedge clk);
        adc_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset with ch0 deflected and a live strobe: must be ignored.
        reset_n   = 1'b0;
        adc_valid = 1'b1;
        adc_data  = {12'h600, 12'hFFF};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        reset_n   = 1'b1;
        adc_valid = 1'b0;

        // Test 1: ARM blocks stepping until a centre sample.
        send(12'hFFF, 12'h600); chk_all("arm1", 0, 0, 0, 0, 0, 0, 0, 0);
        send(12'hFFF, 12'h600); chk_all("arm2", 0, 0, 0, 0, 0, 0, 0, 0);
        send(12'h600, 12'h600); chk_all("arm_ctr", 0, 0, 0, 0, 0, 0, 0, 0);
        send(12'hFFF, 12'h600); chk_all("first_up", 1, 0, 1, 0, 1, 0, 1, 0);
        idle(1);                chk_all("pulse_end", 1, 0, 0, 0, 1, 0, 0, 0);

        // Test 2: one step per deflection without repeat.
        send(12'h600, 12'h600); chk_all("t2_ctr", 1, 0, 0, 0, 1, 0, 0, 0);
        send(12'h900, 12'h600); chk_all("t2_up", 2, 0, 1, 0, 2, 0, 1, 0);
        send(12'h900, 12'h600); chk_all("t2_hold1", 2, 0, 0, 0, 2, 0, 0, 0);
        send(12'h900, 12'h600); chk_all("t2_hold2", 2, 0, 0, 0, 2, 0, 0, 0);
        send(12'h600, 12'h600); chk_all("t2_rel", 2, 0, 0, 0, 2, 0, 0, 0);

        // Test 3: hysteresis band does not release the hold.
        send(12'h900, 12'h600); chk_all("t3_up", 3, 0, 1, 0, 3, 0, 1, 0);
        send(12'h7F0, 12'h600); chk_all("t3_band", 3, 0, 0, 0, 3, 0, 0, 0);
        send(12'h900, 12'h600); chk_all("t3_noreup", 3, 0, 0, 0, 3, 0, 0, 0);
        send(12'h600, 12'h600); chk_all("t3_rel", 3, 0, 0, 0, 3, 0, 0, 0);
        send(12'h900, 12'h600); chk_all("t3_up2", 4, 0, 1, 0, 4, 0, 1, 0);
        send(12'h600, 12'h600); chk_all("t3_rel2", 4, 0, 0, 0, 4, 0, 0, 0);

        // Tests 4/5: simultaneous opposite steps; wrap vs clamp at 0.
        send(12'h900, 12'h100); chk_all("t5_both", 5, 15, 1, 2, 5, 0, 1, 0);
        adc_data = {12'hFFF, 12'h000};
        idle(3);                chk_all("t5_idle", 5, 15, 0, 0, 5, 0, 0, 0);

        // Direct reversals on ch1: wrap up past max, then back down.
        send(12'h600, 12'hFFF); chk_all("rev_up", 5, 0, 2, 0, 5, 1, 2, 0);
        send(12'h600, 12'h100); chk_all("rev_dn", 5, 15, 0, 2, 5, 0, 0, 2);
        send(12'h600, 12'h600); chk_all("rev_rel", 5, 15, 0, 0, 5, 0, 0, 0);

        // Reset mid-hold returns to ARM.
        send(12'h900, 12'h600); chk_all("pre_rst", 6, 15, 1, 0, 6, 0, 1, 0);
        @(negedge clk);
        reset_n   = 1'b0;
        adc_valid = 1'b1;
        adc_data  = {12'h600, 12'h900};
        repeat (2) @(negedge clk);
        chk_all("mid_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        reset_n   = 1'b1;
        adc_valid = 1'b0;
        send(12'h900, 12'h600); chk_all("rst_arm", 0, 0, 0, 0, 0, 0, 0, 0);
        send(12'h600, 12'h600); chk_all("rst_ctr", 0, 0, 0, 0, 0, 0, 0, 0);
        send(12'h900, 12'h600); chk_all("rst_up", 1, 0, 1, 0, 1, 0, 1, 0);
        send(12'h600, 12'h600); chk_all("rst_rel", 1, 0, 0, 0, 1, 0, 0, 0);

        // Exact threshold edges: 'h800 is centre-side, 'h801 is UP, 'h300 is DN.
        send(12'h800, 12'h600); chk_all("th_800", 1, 0, 0, 0, 1, 0, 0, 0);
        send(12'h801, 12'h600); chk_all("th_801", 2, 0, 1, 0, 2, 0, 1, 0);
        send(12'h600, 12'h300); chk_all("th_300", 2, 15, 0, 2, 2, 0, 0, 0);
        send(12'h600, 12'h600); chk_all("th_rel", 2, 15, 0, 0, 2, 0, 0, 0);

`ifdef JOYSTICK_STEPPER_AUTO_REPEAT_EN
        // Test 6: 16 held samples step on samples 1, 8, 12 and 16.
        begin
            int exp_v;
            int stp;
            exp_v = 2;
            for (int k = 1; k <= 16; k++) begin
                stp = (k == 1 || k == 8 || k == 12 || k == 16) ? 1 : 0;
                exp_v += stp;
                send(12'hA00, 12'h600);
                chk_all($sformatf("rpt%0d", k), exp_v, 15, stp, 0, exp_v, 0, stp, 0);
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
